// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit sides.
// Contents: receiver FSM state enum, default bit timing, half-bit helper.
// No ports; imported with import uart_pkg::*.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default link timing: 100 MHz core clock, 115200 baud.
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int HALF_BIT         = DEF_CLKS_PER_BIT / 2;

  // Half-bit offset for a parameterised bit period (start-bit mid-point).
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-word handshake between the UART receiver and its consumer.
// Signals: RX_Data_out/RX_Data_valid (word + valid), RX_Data_ready (consumer accept),
//          Framing_error/Overrun_error (one-cycle status pulses).
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int WORD_SIZE = 8
);

  logic [WORD_SIZE-1:0] RX_Data_out;
  logic                 RX_Data_valid;
  logic                 RX_Data_ready;
  logic                 Framing_error;
  logic                 Overrun_error;

  modport master (
    output RX_Data_out,
    output RX_Data_valid,
    input  RX_Data_ready,
    output Framing_error,
    output Overrun_error
  );

  modport slave (
    input  RX_Data_out,
    input  RX_Data_valid,
    output RX_Data_ready,
    input  Framing_error,
    input  Overrun_error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the async RX pin plus a previous-value flop.
// Latency: rx_sync follows the pin 2 cycles later; rx_fall is a 1-cycle strobe on a 1->0 step.
// Ports: clk, reset_b (sync, active-low), rx_in (async pin) -> rx_sync, rx_fall.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_b,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // All three reset to the idle-high line level so a line that is already low
  // when reset releases never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_sync = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial-to-parallel receiver with a one-word valid/ready holding register.
// Latency: valid rises 3 + CLKS_PER_BIT/2 + (WORD_SIZE+1)*CLKS_PER_BIT cycles after the pin goes low.
// Backpressure: no stall; a word arriving while the previous one is unconsumed overwrites it
// and pulses Overrun_error. Ports: clk, reset_b, RX_Data_in, rx_if (uart_rx_if.master).
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = 8,
  parameter int WORD_SIZE_WIDTH = 4,
  parameter int CLKS_PER_BIT    = 868,
  parameter int CLK_COUNT_WIDTH = 10
) (
  input  logic      clk,
  input  logic      reset_b,
  input  logic      RX_Data_in,
  uart_rx_if.master rx_if
);

  localparam int HALF = half_bit(CLKS_PER_BIT);

  localparam logic [CLK_COUNT_WIDTH-1:0] HALF_LAST = CLK_COUNT_WIDTH'(HALF - 1);
  localparam logic [CLK_COUNT_WIDTH-1:0] BIT_LAST  = CLK_COUNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [WORD_SIZE_WIDTH-1:0] WORD_LAST = WORD_SIZE_WIDTH'(WORD_SIZE - 1);

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .rx_in   (RX_Data_in),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  uart_state_e                state_q, state_d;
  logic [CLK_COUNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [WORD_SIZE_WIDTH-1:0] bit_q,   bit_d;
  logic [WORD_SIZE-1:0]       shift_q, shift_d;
  logic [WORD_SIZE-1:0]       data_q,  data_d;
  logic                       valid_q, valid_d;
  logic                       ferr_q,  ferr_d;
  logic                       oerr_q,  oerr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CLK_COUNT_WIDTH'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    // Consumer handshake: valid only drops when ready is seen with it.
    valid_d = valid_q & ~rx_if.RX_Data_ready;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Edge-triggered start: a line stuck low (break) never starts a frame.
        if (rx_fall) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // High at mid-start means a glitch; drop it silently.
          state_d = rx_sync ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first: shift right so it ends up at bit 0.
          shift_d = {rx_sync, shift_q[WORD_SIZE-1:1]};
          if (bit_q == WORD_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + WORD_SIZE_WIDTH'(1);
          end
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // Back to IDLE at stop mid-bit so a start edge half a bit later is caught.
          state_d = IDLE;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // A same-edge ready consumes the old word, so that is not an overrun.
            oerr_d  = valid_q & ~rx_if.RX_Data_ready;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx_if.RX_Data_out   = data_q;
  assign rx_if.RX_Data_valid = valid_q;
  assign rx_if.Framing_error = ferr_q;
  assign rx_if.Overrun_error = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit, 8-bit words.
// Stimulus drives the serial pin bit by bit; expected values are hand-computed constants.
// Ports: none (top-level bench).
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk;
  logic reset_b;
  logic rx;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;

  uart_rx_if #(.WORD_SIZE(8)) rx_if ();

  uart_rx #(
    .WORD_SIZE       (8),
    .WORD_SIZE_WIDTH (4),
    .CLKS_PER_BIT    (CPB),
    .CLK_COUNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .RX_Data_in (rx),
    .rx_if      (rx_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles each error flag is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_if.Framing_error === 1'b1) ferr_cnt++;
    if (rx_if.Overrun_error === 1'b1) oerr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame: start, 8 data bits LSB first, stop. Line is left at the stop level.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    rx = 1'b1;
    rx_if.RX_Data_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (rx_if.RX_Data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", rx_if.RX_Data_out);
    end
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", rx_if.RX_Data_valid);
    end
    checks++;
    if (rx_if.Framing_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr: got %b expected 0", rx_if.Framing_error);
    end
    checks++;
    if (rx_if.Overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_oerr: got %b expected 0", rx_if.Overrun_error);
    end
    reset_b = 1'b1;
    repeat (5) tick();
  endtask

  // 0xA5 with ready held high: valid is low after edge 154, high after 155, low after 156.
  task automatic test_basic();
    rx_if.RX_Data_ready = 1'b1;
    fork
      drive_frame(8'hA5, 1'b1);
      begin
        repeat (154) tick();
        checks++;
        if (rx_if.RX_Data_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_valid_early: got %b expected 0 at edge 154", rx_if.RX_Data_valid);
        end
        tick();
        checks++;
        if (rx_if.RX_Data_valid !== 1'b1) begin
          errors++;
          $display("FAIL basic_valid_rise: got %b expected 1 at edge 155", rx_if.RX_Data_valid);
        end
        checks++;
        if (rx_if.RX_Data_out !== 8'hA5) begin
          errors++;
          $display("FAIL basic_data: got %h expected a5", rx_if.RX_Data_out);
        end
        tick();
        checks++;
        if (rx_if.RX_Data_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_valid_clear: got %b expected 0 at edge 156", rx_if.RX_Data_valid);
        end
      end
    join
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int f0, o0;
    f0 = ferr_cnt;
    o0 = oerr_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (200) tick();
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_valid: got %b expected 0", rx_if.RX_Data_valid);
    end
    checks++;
    if ((ferr_cnt - f0) !== 0 || (oerr_cnt - o0) !== 0) begin
      errors++;
      $display("FAIL glitch_errors: got ferr=%0d oerr=%0d expected 0 0", ferr_cnt - f0, oerr_cnt - o0);
    end
    checks++;
    if (rx_if.RX_Data_out !== 8'hA5) begin
      errors++;
      $display("FAIL glitch_data: got %h expected a5", rx_if.RX_Data_out);
    end
  endtask

  task automatic test_framing();
    int f0, o0;
    f0 = ferr_cnt;
    o0 = oerr_cnt;
    rx_if.RX_Data_ready = 1'b1;
    drive_frame(8'h3C, 1'b0);
    checks++;
    if ((ferr_cnt - f0) !== 1) begin
      errors++;
      $display("FAIL framing_pulse: got %0d high cycles expected 1", ferr_cnt - f0);
    end
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0) begin
      errors++;
      $display("FAIL framing_valid: got %b expected 0", rx_if.RX_Data_valid);
    end
    repeat (100) tick();
    rx = 1'b1;
    repeat (200) tick();
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0 || (ferr_cnt - f0) !== 1 || (oerr_cnt - o0) !== 0) begin
      errors++;
      $display("FAIL framing_break: got valid=%b ferr=%0d oerr=%0d expected 0 1 0",
               rx_if.RX_Data_valid, ferr_cnt - f0, oerr_cnt - o0);
    end
    checks++;
    if (rx_if.RX_Data_out !== 8'hA5) begin
      errors++;
      $display("FAIL framing_hold: got %h expected a5", rx_if.RX_Data_out);
    end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = oerr_cnt;
    rx_if.RX_Data_ready = 1'b0;
    drive_frame(8'h11, 1'b1);
    checks++;
    if (rx_if.RX_Data_valid !== 1'b1 || rx_if.RX_Data_out !== 8'h11) begin
      errors++;
      $display("FAIL overrun_first: got valid=%b data=%h expected 1 11",
               rx_if.RX_Data_valid, rx_if.RX_Data_out);
    end
    drive_frame(8'h22, 1'b1);
    checks++;
    if ((oerr_cnt - o0) !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d high cycles expected 1", oerr_cnt - o0);
    end
    checks++;
    if (rx_if.RX_Data_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_valid: got %b expected 1", rx_if.RX_Data_valid);
    end
    checks++;
    if (rx_if.RX_Data_out !== 8'h22) begin
      errors++;
      $display("FAIL overrun_data: got %h expected 22", rx_if.RX_Data_out);
    end
    rx_if.RX_Data_ready = 1'b1;
    tick();
    rx_if.RX_Data_ready = 1'b0;
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_consume: got %b expected 0", rx_if.RX_Data_valid);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_midframe();
    int f0, o0;
    rx_if.RX_Data_ready = 1'b0;
    drive_frame(8'h33, 1'b1);
    f0 = ferr_cnt;
    o0 = oerr_cnt;
    fork
      drive_frame(8'hFF, 1'b1);
      begin
        repeat (60) tick();
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        checks++;
        if (rx_if.RX_Data_valid !== 1'b0 || rx_if.RX_Data_out !== 8'h00) begin
          errors++;
          $display("FAIL midreset_clear: got valid=%b data=%h expected 0 00",
                   rx_if.RX_Data_valid, rx_if.RX_Data_out);
        end
      end
    join
    repeat (20) tick();
    checks++;
    if (rx_if.RX_Data_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_tail: got valid=%b expected 0", rx_if.RX_Data_valid);
    end
    drive_frame(8'h5A, 1'b1);
    checks++;
    if (rx_if.RX_Data_valid !== 1'b1 || rx_if.RX_Data_out !== 8'h5A) begin
      errors++;
      $display("FAIL midreset_next: got valid=%b data=%h expected 1 5a",
               rx_if.RX_Data_valid, rx_if.RX_Data_out);
    end
    checks++;
    if ((ferr_cnt - f0) !== 0 || (oerr_cnt - o0) !== 0) begin
      errors++;
      $display("FAIL midreset_errors: got ferr=%0d oerr=%0d expected 0 0", ferr_cnt - f0, oerr_cnt - o0);
    end
    rx_if.RX_Data_ready = 1'b1;
    tick();
    rx_if.RX_Data_ready = 1'b0;
    repeat (10) tick();
  endtask

  // Ready asserted only for the edge that loads the second word (edge 160+155).
  task automatic test_ready_on_load();
    int o0;
    o0 = oerr_cnt;
    rx_if.RX_Data_ready = 1'b0;
    fork
      begin
        drive_frame(8'hC3, 1'b1);
        drive_frame(8'h96, 1'b1);
      end
      begin
        repeat (314) tick();
        checks++;
        if (rx_if.RX_Data_valid !== 1'b1 || rx_if.RX_Data_out !== 8'hC3) begin
          errors++;
          $display("FAIL load_first: got valid=%b data=%h expected 1 c3",
                   rx_if.RX_Data_valid, rx_if.RX_Data_out);
        end
        rx_if.RX_Data_ready = 1'b1;
        tick();
        rx_if.RX_Data_ready = 1'b0;
        checks++;
        if (rx_if.RX_Data_valid !== 1'b1 || rx_if.RX_Data_out !== 8'h96) begin
          errors++;
          $display("FAIL load_second: got valid=%b data=%h expected 1 96",
                   rx_if.RX_Data_valid, rx_if.RX_Data_out);
        end
      end
    join
    checks++;
    if ((oerr_cnt - o0) !== 0) begin
      errors++;
      $display("FAIL load_no_overrun: got %0d overrun cycles expected 0", oerr_cnt - o0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_ready_on_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receiving end of the team's 8N1 UART link, complementing the transmit datapath. Synchronizes the asynchronous RX line, detects and qualifies the start bit, samples each data bit at mid-bit (LSB first), checks the stop bit and presents the word on a valid/ready holding register. Sits between the board RX pin and the acoustics command/packet parser.

## Interface
- WORD_SIZE, 8: data bits per frame
- WORD_SIZE_WIDTH, 4: width of bit counter; must hold WORD_SIZE
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); even, ≥ 4
- CLK_COUNT_WIDTH, 10: width of baud counter; must hold CLKS_PER_BIT-1

- clk  input  1  system clock, all logic on rising edge
- reset_b  input  1  synchronous, active-low reset
- RX_Data_in  input  1  asynchronous serial line, idle high
- RX_Data_ready  input  1  consumer accepts word when high with RX_Data_valid
- RX_Data_out  output  WORD_SIZE  received word, stable while RX_Data_valid high
- RX_Data_valid  output  1  holding register contains an unconsumed word
- Framing_error  output  1  one-cycle pulse: stop bit sampled low
- Overrun_error  output  1  one-cycle pulse: unconsumed word overwritten

## Operation
- RX_Data_in passes through 2-flop synchronizer (flops reset to 1); plus one "previous" flop for edge detect (reset 1). FSM uses synchronized value only.
- States: IDLE, START, DATA, STOP. Baud counter (CLK_COUNT_WIDTH) and bit counter (WORD_SIZE_WIDTH) cleared on every state entry.
- IDLE: on synchronized falling edge (prev=1, cur=0) -> START. Line held low without a falling edge never starts a frame (break tolerance).
- START: count to CLKS_PER_BIT/2-1, sample. Low -> DATA. High -> IDLE (glitch rejected, no error flag).
- DATA: every CLKS_PER_BIT cycles sample, shift in LSB first (new bit enters at MSB, shift right). After WORD_SIZE samples -> STOP.
- STOP: after CLKS_PER_BIT cycles sample. High -> load shift register into RX_Data_out, set RX_Data_valid. Low -> Framing_error pulse, word discarded, holding register untouched. Both -> IDLE.
- Handshake: RX_Data_valid && RX_Data_ready at an edge -> valid clears that edge. Valid never drops without ready.
- Load while valid high and ready low: new word overwrites, valid stays high, Overrun_error pulses. Load coinciding with ready high: new word loaded, valid stays high, no overrun.
- Framing error and overrun cannot occur in same cycle.
- Reset mid-frame: FSM -> IDLE, counters 0, shift register 0, holding register discarded; next frame requires fresh falling edge after line returns high.

## Timing
- Reset values: RX_Data_out = 0, RX_Data_valid = 0, Framing_error = 0, Overrun_error = 0, state IDLE.
- Sample points: start at CLKS_PER_BIT/2 after edge detect, data/stop at further CLKS_PER_BIT multiples (mid-bit).
- Latency: counting first edge sampling pin low as edge 1, RX_Data_valid is high after edge 3 + CLKS_PER_BIT/2 + (WORD_SIZE+1)·CLKS_PER_BIT.
- Error pulses high exactly one cycle, registered, on the same edge the stop sample would load data.
- FSM returns to IDLE at stop mid-bit, so back-to-back frames (next start edge half a bit later) are received without loss.
- All outputs registered; no combinational path input -> output.

## Structure
- Package uart_pkg: state enum (IDLE, START, DATA, STOP), localparam HALF_BIT = CLKS_PER_BIT/2; shared with transmit side.
- Sub-module uart_rx_sync: 2-flop synchronizer + previous-value flop, outputs synchronized level and falling-edge strobe, reset to idle-high.
- Baud counter, bit counter, shift register, FSM and holding register stay in uart_rx.

## Test plan (CLKS_PER_BIT=16, WORD_SIZE=8)
- Reset, line high, send 0xA5 8N1, ready held high -> RX_Data_valid rises after edge 155, RX_Data_out = 0xA5, valid high one cycle.
- 4-cycle low glitch on idle line -> no state advance past START, valid and errors stay 0.
- Frame 0x3C with stop bit low -> Framing_error one-cycle pulse, valid stays 0; line held low 100 cycles then high -> no spurious frame.
- Send 0x11 then 0x22 back-to-back, ready low -> valid stays high, Overrun_error pulses once, RX_Data_out = 0x22; ready high one cycle -> valid clears.
- reset_b low for 1 cycle mid-DATA of 0xFF, then send 0x5A -> only 0x5A delivered, no errors.
- Ready asserted on exact load edge of second word -> no overrun, RX_Data_out = second word, valid remains high.
